sccb_responder: RTL and testbench
=================================

// Module: sccb_responder
// PURPOSE
//  SCCB target (slave) for the 3-phase write bus driven by our SCCB master; it models the OV7670 register port.
//  Samples SIOC/SIOD, decodes ID/register/value phases, and updates a REG_DEPTH x 8 shadow register file.
//  Used in the camera bring-up bench and on-FPGA as a loopback target to check config ROM sequences.
// PARAMETERS
//  CLK_FREQ   25_000_000  system clock in Hz; used only for the bus-rate assertion
//  SCCB_FREQ  100_000     maximum SIOC rate; requires CLK_FREQ/SCCB_FREQ >= 16
//  DEVICE_ID  8'h42       write address of the target; bit0 = 0
//  REG_DEPTH  256         shadow register count; the address is truncated to $clog2(REG_DEPTH) bits
// PORTS
//  clk_i       in   1   system clock
//  rst_ni      in   1   asynchronous, active-low reset
//  sioc_i      in   1   SIOC bus level (true polarity, asynchronous)
//  siod_i      in   1   SIOD bus level (true polarity, asynchronous)
//  siod_oe_o   out  1   1 = pull SIOD low (open-drain enable)
//  wr_en_o     out  1   one-cycle pulse when a register is written
//  wr_addr_o   out  8   register address of the write
//  wr_data_o   out  8   value of the write
//  rd_addr_i   in   8   user-side read address
//  rd_data_o   out  8   combinational read of the shadow register file
//  busy_o      out  1   1 between START and STOP
//  err_o       out  1   sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, shadow registers 0, state IDLE. Reset mid-transfer aborts it with no write.
//  - Sync: a 2-FF synchronizer plus edge detect on each line. Bus events act 3 clk after the pin edge.
//  - Bus events:
//    START = SIOD falls while SIOC is high. STOP = SIOD rises while SIOC is high.
//    Data bits are sampled MSB first on the SIOC rising edge.
//  - States: IDLE, ID, ACK_ID, REG, ACK_REG, DATA, ACK_DATA, IGNORE.
//    IDLE -START-> ID.
//    After 8 bits, ID goes to ACK_ID if the byte == DEVICE_ID, else to IGNORE.
//    ACK_ID -> REG -> ACK_REG -> DATA -> ACK_DATA -> IGNORE.
//  - 9th bit (don't-care/ACK):
//    siod_oe_o rises on the SIOC falling edge after the 8th bit of an accepted byte.
//    It falls on the SIOC falling edge after the 9th bit.
//  - Write:
//    On the 8th DATA bit: wr_en_o = 1 for exactly 1 clk, wr_addr_o/wr_data_o updated in the same cycle.
//    The shadow register updates on the next edge.
//    wr_addr_o/wr_data_o hold their values until the next write.
//  - Boundaries:
//    STOP in any state -> IDLE, busy_o = 0, siod_oe_o = 0. A STOP before 8 DATA bits causes no write and sets err_o.
//    START in any non-IDLE state (repeated start) -> ID with the bit counter cleared.
//    Bytes beyond the value byte -> IGNORE and set err_o.
//    An ID mismatch does not set err_o.
//    An address >= REG_DEPTH is truncated (wrap-around).
//  - Bit counter is 4 bits, cleared at START and on each ACK exit.
// CONFIGURATION
//  SCCB_RESPONDER_READ_EN defined:
//    Adds the 2-phase write (ID, REG, STOP), which latches the read pointer.
//    Adds the read transaction ID = DEVICE_ID|1: the target drives the shadow[ptr] bits via siod_oe_o = ~bit.
//    Bits change on the SIOC falling edge. The master's NA bit is ignored.
//    A 2-phase write does not set err_o.
//    Adds states RD_DATA and RD_NA.
//  Undefined:
//    A DEVICE_ID|1 address -> IGNORE.
//    A 2-phase write sets err_o and does not write.
// STRUCTURE
//  - sccb_pkg: sccb_state_e enum, SCCB_ID_WRITE = 8'h42, SCCB_ID_READ = 8'h43, SYNC_STAGES = 2.
//  - Sub-module sccb_line_sync:
//    2-FF sync plus edge detect for SIOC/SIOD.
//    Outputs sioc_rise, sioc_fall, start, stop.
// TESTING (bench drives the SCCB master at SCCB_FREQ = 1_000_000 for speed)
//  1. Write 42/12/80 -> wr_en_o = 1 for 1 clk, wr_addr_o = 12, wr_data_o = 80.
//     Afterwards rd_addr_i = 12 -> rd_data_o = 80. err_o = 0.
//  2. Write 60/12/55 -> no wr_en_o, siod_oe_o never 1, shadow[12] stays 80.
//  3. Two back-to-back writes 42/3A/04 then 42/3A/0C -> two pulses; shadow[3A] = 0C.
//  4. Bench bit-bangs START, ID 42, REG 11, then STOP -> no write, err_o = 1.
//     Next valid write still succeeds.
//  5. Assert rst_ni low during the DATA phase -> outputs go 0 asynchronously, shadow regs are 0, no write.
//     After release, a write 42/11/01 works.
//  6. (READ_EN) Write 42/0A/76, then 2-phase 42/0A, then read 43 -> siod_oe_o pattern encodes 76 MSB first.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder slice.
// The read/pointer states are only reached when SCCB_RESPONDER_READ_EN is defined.
`timescale 1ns/1ps
package sccb_pkg;

    localparam logic [7:0] SCCB_ID_WRITE = 8'h42;
    localparam logic [7:0] SCCB_ID_READ  = 8'h43;
    localparam int         SYNC_STAGES   = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ACK_ID,
        S_REG,
        S_ACK_REG,
        S_DATA,
        S_ACK_DATA,
        S_IGNORE,
        S_RD_DATA,
        S_RD_NA
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SIOC/SIOD into the clock domain and derives clock edges plus START/STOP.
`timescale 1ns/1ps
module sccb_line_sync
    import sccb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sioc,
    input  logic siod,
    output logic siod_level,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_prev;
    logic                   siod_prev;
    logic                   sioc_level;

    // Idle bus is high, so reset to 1 to avoid phantom edges on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_prev <= 1'b1;
            siod_prev <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
            sioc_prev <= sioc_sync[SYNC_STAGES-1];
            siod_prev <= siod_sync[SYNC_STAGES-1];
        end
    end

    assign sioc_level = sioc_sync[SYNC_STAGES-1];
    assign siod_level = siod_sync[SYNC_STAGES-1];
    assign sioc_rise  = sioc_level & ~sioc_prev;
    assign sioc_fall  = ~sioc_level & sioc_prev;
    assign start      = siod_prev & ~siod_level & sioc_level & sioc_prev;
    assign stop       = ~siod_prev & siod_level & sioc_level & sioc_prev;

endmodule

// File: rtl/sccb_responder.sv
// SCCB write target with a shadow register file, modelling the OV7670 register port.
// Define SCCB_RESPONDER_READ_EN to add 2-phase pointer writes and read transactions.
`timescale 1ns/1ps
module sccb_responder
    import sccb_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned SCCB_FREQ = 100_000,
    parameter logic [7:0]  DEVICE_ID = SCCB_ID_WRITE,
    parameter int unsigned REG_DEPTH = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    input  logic [7:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    if (CLK_FREQ / SCCB_FREQ < 16) begin : g_rate_check
        $error("sccb_responder: CLK_FREQ/SCCB_FREQ must be at least 16");
    end

    sccb_state_e state, state_n;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  reg_addr;
    logic        overrun;
    logic        is_read;
    logic        siod_level, sioc_rise, sioc_fall, start, stop;
    logic        oe_n, clr_cnt, set_err, do_write, latch_reg, set_overrun, mark_read;
    logic [7:0]  shadow [REG_DEPTH];

`ifdef SCCB_RESPONDER_READ_EN
    localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;
    logic [7:0] ptr;
    logic [7:0] rd_shift;
    logic       latch_ptr, load_rd, shift_rd;
`endif

    sccb_line_sync u_sync (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .sioc      (sioc_i),
        .siod      (siod_i),
        .siod_level(siod_level),
        .sioc_rise (sioc_rise),
        .sioc_fall (sioc_fall),
        .start     (start),
        .stop      (stop)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_n;
    end

    // Byte phases finish on the SIOC fall after bit 8; ACK phases end on the fall after bit 9.
    always_comb begin
        state_n     = state;
        oe_n        = siod_oe_o;
        clr_cnt     = 1'b0;
        set_err     = 1'b0;
        do_write    = 1'b0;
        latch_reg   = 1'b0;
        set_overrun = 1'b0;
        mark_read   = 1'b0;
`ifdef SCCB_RESPONDER_READ_EN
        latch_ptr   = 1'b0;
        load_rd     = 1'b0;
        shift_rd    = 1'b0;
`endif
        if (start) begin
            state_n = S_ID;
            oe_n    = 1'b0;
            clr_cnt = 1'b1;
        end else if (stop) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            clr_cnt = 1'b1;
            if (!is_read) begin
                case (state)
                    S_ACK_ID, S_REG, S_ACK_REG: set_err = 1'b1;
                    S_DATA: begin
                        // The STOP itself clocks one bit, so count < 2 means no data byte was started.
                        if (bit_cnt < 4'd2) begin
`ifdef SCCB_RESPONDER_READ_EN
                            latch_ptr = 1'b1;
`else
                            set_err   = 1'b1;
`endif
                        end else if (bit_cnt < 4'd8) begin
                            set_err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (state == S_DATA && sioc_rise && bit_cnt == 4'd7) do_write = 1'b1;
            case (state)
                S_ID: if (sioc_fall && bit_cnt == 4'd8) begin
                    if (shreg == DEVICE_ID) begin
                        state_n = S_ACK_ID;
                        oe_n    = 1'b1;
`ifdef SCCB_RESPONDER_READ_EN
                    end else if (shreg == READ_ID) begin
                        state_n   = S_ACK_ID;
                        oe_n      = 1'b1;
                        mark_read = 1'b1;
`endif
                    end else begin
                        state_n = S_IGNORE;
                    end
                end
                S_REG: if (sioc_fall && bit_cnt == 4'd8) begin
                    state_n   = S_ACK_REG;
                    oe_n      = 1'b1;
                    latch_reg = 1'b1;
                end
                S_DATA: if (sioc_fall && bit_cnt == 4'd8) begin
                    state_n = S_ACK_DATA;
                    oe_n    = 1'b1;
                end
                S_ACK_ID: if (sioc_fall && bit_cnt == 4'd9) begin
                    clr_cnt = 1'b1;
                    oe_n    = 1'b0;
                    state_n = S_REG;
`ifdef SCCB_RESPONDER_READ_EN
                    if (is_read) begin
                        state_n = S_RD_DATA;
                        load_rd = 1'b1;
                        oe_n    = ~shadow[ptr[AW-1:0]][7];
                    end
`endif
                end
                S_ACK_REG: if (sioc_fall && bit_cnt == 4'd9) begin
                    clr_cnt = 1'b1;
                    oe_n    = 1'b0;
                    state_n = S_DATA;
                end
                S_ACK_DATA: if (sioc_fall && bit_cnt == 4'd9) begin
                    clr_cnt     = 1'b1;
                    oe_n        = 1'b0;
                    state_n     = S_IGNORE;
                    set_overrun = 1'b1;
                end
                S_IGNORE: if (overrun && sioc_rise && bit_cnt == 4'd7) set_err = 1'b1;
`ifdef SCCB_RESPONDER_READ_EN
                S_RD_DATA: if (sioc_fall) begin
                    if (bit_cnt == 4'd8) begin
                        state_n = S_RD_NA;
                        oe_n    = 1'b0;
                    end else if (bit_cnt != 4'd0) begin
                        shift_rd = 1'b1;
                        oe_n     = ~rd_shift[6];
                    end
                end
                S_RD_NA: if (sioc_fall && bit_cnt == 4'd9) begin
                    state_n = S_IGNORE;
                    clr_cnt = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            reg_addr  <= '0;
            overrun   <= 1'b0;
            is_read   <= 1'b0;
            siod_oe_o <= 1'b0;
            err_o     <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            siod_oe_o <= oe_n;
            wr_en_o   <= do_write;
            if (clr_cnt)                            bit_cnt <= '0;
            else if (sioc_rise && state != S_IDLE)  bit_cnt <= bit_cnt + 4'd1;
            if (sioc_rise) shreg <= {shreg[6:0], siod_level};
            if (latch_reg) reg_addr <= shreg;
            if (do_write) begin
                wr_addr_o <= reg_addr;
                wr_data_o <= {shreg[6:0], siod_level};
            end
            if (set_err) err_o <= 1'b1;
            if (start || stop) begin
                overrun <= 1'b0;
                is_read <= 1'b0;
            end else begin
                if (set_overrun) overrun <= 1'b1;
                if (mark_read)   is_read <= 1'b1;
            end
        end
    end

`ifdef SCCB_RESPONDER_READ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr      <= '0;
            rd_shift <= '0;
        end else begin
            if (latch_ptr) ptr <= reg_addr;
            if (load_rd)       rd_shift <= shadow[ptr[AW-1:0]];
            else if (shift_rd) rd_shift <= {rd_shift[6:0], 1'b0};
        end
    end
`endif

    // Writes land one cycle after the wr_en_o pulse; the address wraps to AW bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_DEPTH; i++) shadow[i] <= '0;
        end else if (wr_en_o) begin
            shadow[wr_addr_o[AW-1:0]] <= wr_data_o;
        end
    end

    assign rd_data_o = shadow[rd_addr_i[AW-1:0]];
    assign busy_o    = (state != S_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// Scoreboard bench for sccb_responder: bit-bangs an SCCB master and checks writes against a register model.
`timescale 1ns/1ps
module tb_sccb_responder;

    localparam int CLK_HALF = 20;
    localparam int QTR      = 250;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sioc = 1'b1;
    logic       sda_m = 1'b1;
    logic       siod_line;
    logic       siod_oe, wr_en, busy, err;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    logic [15:0] exp_q [$];
    logic [7:0]  model_mem [256];
    logic        model_err;
    logic [7:0]  model_ptr;
    int          checks = 0;
    int          failures = 0;
    int          oe_hits = 0;
    bit          watch_oe = 1'b0;

    assign siod_line = sda_m & ~siod_oe;

    always #CLK_HALF clk = ~clk;

    sccb_responder #(
        .CLK_FREQ (25_000_000),
        .SCCB_FREQ(1_000_000),
        .DEVICE_ID(8'h42),
        .REG_DEPTH(256)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .sioc_i   (sioc),
        .siod_i   (siod_line),
        .siod_oe_o(siod_oe),
        .wr_en_o  (wr_en),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .busy_o   (busy),
        .err_o    (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got %0h/%0h, expected no write", wr_addr, wr_data);
            end else begin
                logic [15:0] exp;
                exp = exp_q.pop_front();
                checkOutput("write_pulse", {wr_addr, wr_data}, {16'h0, exp});
            end
        end
        if (watch_oe && siod_oe) oe_hits++;
    end

    task automatic busStart();
        sda_m = 1'b1; sioc = 1'b1; #QTR;
        sda_m = 1'b0; #QTR;
        sioc = 1'b0; #QTR;
    endtask

    task automatic busStop();
        sda_m = 1'b0; #QTR;
        sioc = 1'b1; #QTR;
        sda_m = 1'b1; #(2*QTR);
    endtask

    task automatic sendBit(input logic b);
        sda_m = b; #QTR;
        sioc = 1'b1; #(2*QTR);
        sioc = 1'b0; #QTR;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic exp_ack, input string name);
        logic ack;
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        sda_m = 1'b1; #QTR;
        sioc = 1'b1; #QTR;
        ack = ~siod_line;
        #QTR;
        sioc = 1'b0; #QTR;
        checkOutput(name, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    task automatic readByte(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #QTR;
            sioc = 1'b1; #QTR;
            b = {b[6:0], siod_line};
            #QTR;
            sioc = 1'b0; #QTR;
        end
        sendBit(1'b1);
    endtask

    // Full 3-phase write; the model only changes when the ID addresses this target.
    task automatic applyStimulus(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data);
        logic hit;
        hit = (id == 8'h42);
        busStart();
        sendByte(id, hit, "ack_id");
        sendByte(addr, hit, "ack_reg");
        if (hit) begin
            exp_q.push_back({addr, data});
            model_mem[addr] = data;
        end
        sendByte(data, hit, "ack_data");
        busStop();
    endtask

    task automatic checkReg(input logic [7:0] addr);
        @(negedge clk);
        rd_addr = addr;
        #1;
        checkOutput("rd_data", {24'h0, rd_data}, {24'h0, model_mem[addr]});
    endtask

    initial begin
        logic [7:0] id, addr, data, got;
        rd_addr = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_err = 1'b0;
        model_ptr = 8'h00;

        #100;
        checkOutput("reset_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("reset_oe", {31'h0, siod_oe}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_err", {31'h0, err}, 32'h0);
        checkOutput("reset_wr_bus", {16'h0, wr_addr, wr_data}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #200;

        applyStimulus(8'h42, 8'h12, 8'h80);
        checkReg(8'h12);
        checkOutput("err_after_write", {31'h0, err}, {31'h0, model_err});

        watch_oe = 1'b1;
        oe_hits  = 0;
        applyStimulus(8'h60, 8'h12, 8'h55);
        watch_oe = 1'b0;
        checkOutput("oe_on_foreign_id", oe_hits, 0);
        checkReg(8'h12);

        applyStimulus(8'h42, 8'h3A, 8'h04);
        applyStimulus(8'h42, 8'h3A, 8'h0C);
        checkReg(8'h3A);

        busStart();
        sendByte(8'h42, 1'b1, "ack_id_2ph");
        sendByte(8'h11, 1'b1, "ack_reg_2ph");
        busStop();
`ifdef SCCB_RESPONDER_READ_EN
        model_ptr = 8'h11;
`else
        model_err = 1'b1;
`endif
        checkOutput("err_after_2phase", {31'h0, err}, {31'h0, model_err});
        checkOutput("busy_after_stop", {31'h0, busy}, 32'h0);
        applyStimulus(8'h42, 8'h11, 8'h5A);
        checkReg(8'h11);

        for (int n = 0; n < 12; n++) begin
            id = 8'h42;
            if ($urandom_range(0, 3) == 0) begin
                id = 8'($urandom);
                while (id == 8'h42 || id == 8'h43) id = 8'($urandom);
            end
            addr = 8'($urandom);
            data = 8'($urandom);
            applyStimulus(id, addr, data);
            checkReg(addr);
        end
        checkOutput("err_after_random", {31'h0, err}, {31'h0, model_err});

        busStart();
        checkOutput("busy_in_txn", {31'h0, busy}, 32'h1);
        sendByte(8'h42, 1'b1, "ack_id_rst");
        sendByte(8'h12, 1'b1, "ack_reg_rst");
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #3;
        checkOutput("async_rst_wr_en", {31'h0, wr_en}, 32'h0);
        checkOutput("async_rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("async_rst_err", {31'h0, err}, 32'h0);
        checkOutput("async_rst_wr_bus", {16'h0, wr_addr, wr_data}, 32'h0);
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_err = 1'b0;
        model_ptr = 8'h00;
        rd_addr = 8'h12;
        #1;
        checkOutput("async_rst_shadow", {24'h0, rd_data}, 32'h0);
        sioc  = 1'b1;
        #50 sda_m = 1'b1;
        #300;
        @(negedge clk) rst_n = 1'b1;
        #200;
        applyStimulus(8'h42, 8'h11, 8'h01);
        checkReg(8'h11);
        checkReg(8'h3A);

        checkOutput("err_before_overrun", {31'h0, err}, {31'h0, model_err});
        busStart();
        sendByte(8'h42, 1'b1, "ack_id_ovr");
        sendByte(8'h20, 1'b1, "ack_reg_ovr");
        exp_q.push_back({8'h20, 8'h33});
        model_mem[8'h20] = 8'h33;
        sendByte(8'h33, 1'b1, "ack_data_ovr");
        sendByte(8'h99, 1'b0, "ack_extra_byte");
        busStop();
        model_err = 1'b1;
        checkOutput("err_after_overrun", {31'h0, err}, {31'h0, model_err});
        checkReg(8'h20);

`ifdef SCCB_RESPONDER_READ_EN
        applyStimulus(8'h42, 8'h0A, 8'h76);
        busStart();
        sendByte(8'h42, 1'b1, "ack_id_ptr");
        sendByte(8'h0A, 1'b1, "ack_reg_ptr");
        busStop();
        model_ptr = 8'h0A;
        checkOutput("err_after_ptr_write", {31'h0, err}, {31'h0, model_err});
        busStart();
        sendByte(8'h43, 1'b1, "ack_rd_id");
        readByte(got);
        busStop();
        checkOutput("read_byte", {24'h0, got}, {24'h0, model_mem[model_ptr]});
`endif

        #2000;
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
